// File: rtl/hls2x8_mv_sched.sv
// Block-level sequencer for y = A*x, time-sharing one external combinational multiplier.
// Each column is an ISSUE/ACC pair (BRAM read, then multiply-accumulate); each row ends with one y write.
module hls2x8_mv_sched #(
    parameter int ROWS   = 2,
    parameter int COLS   = 8,
    parameter int DATA_W = 16,
    parameter int A_AW   = 4,
    parameter int X_AW   = 3,
    parameter int Y_AW   = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [A_AW-1:0]   a_address0,
    output logic              a_ce0,
    input  logic [DATA_W-1:0] a_q0,
    output logic [X_AW-1:0]   x_address0,
    output logic              x_ce0,
    input  logic [DATA_W-1:0] x_q0,
    output logic [DATA_W-1:0] mul_din0,
    output logic [DATA_W-1:0] mul_din1,
    input  logic [DATA_W-1:0] mul_dout,
    output logic [Y_AW-1:0]   y_address0,
    output logic              y_ce0,
    output logic              y_we0,
    output logic [DATA_W-1:0] y_d0
);
    localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int C_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [R_W-1:0]    r_row;
    logic [C_W-1:0]    r_col;
    logic [DATA_W-1:0] r_acc;
    logic              w_last_col;
    logic              w_last_row;
    logic [A_AW-1:0]   w_a_addr;

    assign w_last_col = (r_col == C_W'(COLS - 1));
    assign w_last_row = (r_row == R_W'(ROWS - 1));
    assign w_a_addr   = A_AW'(r_row) * A_AW'(COLS) + A_AW'(r_col);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Row/column counters and the accumulator; the product is summed modulo 2^DATA_W.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_row <= '0;
            r_col <= '0;
            r_acc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_row <= '0;
                        r_col <= '0;
                        r_acc <= '0;
                    end
                end
                S_ACC: begin
                    r_acc <= r_acc + mul_dout;
                    if (!w_last_col) begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_acc <= '0;
                    r_col <= '0;
                    if (!w_last_row) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted, whatever state the register holds.
    always_comb begin
        w_next     = r_state;
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        a_ce0      = 1'b0;
        a_address0 = '0;
        x_ce0      = 1'b0;
        x_address0 = '0;
        mul_din0   = '0;
        mul_din1   = '0;
        y_ce0      = 1'b0;
        y_we0      = 1'b0;
        y_address0 = '0;
        y_d0       = '0;
        if (!ap_rst) begin
            case (r_state)
                S_IDLE: begin
                    ap_idle = 1'b1;
                    if (ap_start) begin
                        w_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    a_ce0      = 1'b1;
                    x_ce0      = 1'b1;
                    a_address0 = w_a_addr;
                    x_address0 = X_AW'(r_col);
                    w_next     = S_ACC;
                end
                S_ACC: begin
                    mul_din0 = a_q0;
                    mul_din1 = x_q0;
                    w_next   = w_last_col ? S_WRITE : S_ISSUE;
                end
                S_WRITE: begin
                    y_ce0      = 1'b1;
                    y_we0      = 1'b1;
                    y_address0 = Y_AW'(r_row);
                    y_d0       = r_acc;
                    w_next     = w_last_row ? S_DONE : S_ISSUE;
                end
                S_DONE: begin
                    ap_done  = 1'b1;
                    ap_ready = 1'b1;
                    w_next   = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hls2x8_mv_sched.sv
// Scoreboard bench for hls2x8_mv_sched: memories and multiplier modelled here, expected
// y writes / done cycles queued at stimulus time and checked by a negedge monitor.
module tb_hls2x8_mv_sched;
    localparam int ROWS = 2;
    localparam int COLS = 8;
    localparam int RUN  = ROWS * (2 * COLS + 1) + 1;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [3:0]  a_address0;
    logic        a_ce0;
    logic [15:0] a_q0;
    logic [2:0]  x_address0;
    logic        x_ce0;
    logic [15:0] x_q0;
    logic [15:0] mul_din0, mul_din1, mul_dout;
    logic [0:0]  y_address0;
    logic        y_ce0, y_we0;
    logic [15:0] y_d0;

    logic [15:0] amem [16];
    logic [15:0] xmem [8];
    logic signed [31:0] w_prod;

    hls2x8_mv_sched dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .a_address0(a_address0), .a_ce0(a_ce0), .a_q0(a_q0),
        .x_address0(x_address0), .x_ce0(x_ce0), .x_q0(x_q0),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .y_address0(y_address0), .y_ce0(y_ce0), .y_we0(y_we0), .y_d0(y_d0)
    );

    always #5 ap_clk = ~ap_clk;

    assign w_prod   = $signed(mul_din0) * $signed(mul_din1);
    assign mul_dout = w_prod[15:0];

    always @(posedge ap_clk) begin
        if (a_ce0) a_q0 <= amem[a_address0];
        if (x_ce0) x_q0 <= xmem[x_address0];
    end

    typedef struct { int cyc; int addr; logic [15:0] data; } ywr_t;
    typedef struct { int s; int d; } win_t;

    ywr_t exp_y[$];
    int   exp_done[$];
    win_t wins[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fin_req = 1'b0;
    bit   fin_done = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Reference: each row is the modulo-2^16 sum of 16-bit-truncated signed products.
    function automatic void push_run(input int s, input int nrows, input int d);
        logic [15:0] acc;
        logic signed [31:0] p;
        ywr_t e;
        for (int r = 0; r < nrows; r++) begin
            acc = '0;
            for (int c = 0; c < COLS; c++) begin
                p   = $signed(amem[r * COLS + c]) * $signed(xmem[c]);
                acc = acc + p[15:0];
            end
            e.cyc  = s + (2 * COLS + 1) * (r + 1);
            e.addr = r;
            e.data = acc;
            exp_y.push_back(e);
        end
        if (nrows == ROWS) exp_done.push_back(s + RUN);
        wins.push_back('{s, d});
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    int   rd_idx = 0;
    bit   prev_ce = 1'b0;
    int   prev_a = 0;
    int   prev_x = 0;
    bit   busy;
    int   e_done;
    ywr_t e_y;

    always @(negedge ap_clk) begin
        if (ap_rst) begin
            chk({ap_done, ap_ready, a_ce0, x_ce0, y_ce0, y_we0} == 6'b0, "rst_ctrl",
                int'({ap_done, ap_ready, a_ce0, x_ce0, y_ce0, y_we0}), 0);
            chk((a_address0 == 0) && (x_address0 == 0) && (y_address0 == 0) &&
                (mul_din0 == 0) && (mul_din1 == 0) && (y_d0 == 0), "rst_data", int'(mul_din0), 0);
            rd_idx  = 0;
            prev_ce = 1'b0;
        end else begin
            busy = 1'b0;
            foreach (wins[i]) if (cyc > wins[i].s && cyc <= wins[i].d) busy = 1'b1;
            chk(ap_idle == !busy, "idle", int'(ap_idle), int'(!busy));
            chk(ap_ready == ap_done, "ready_eq_done", int'(ap_ready), int'(ap_done));
            if (ap_done) begin
                if (exp_done.size() == 0) chk(1'b0, "done_unexpected", cyc, -1);
                else begin
                    e_done = exp_done.pop_front();
                    chk(cyc == e_done, "done_cycle", cyc, e_done);
                end
            end
            if (y_ce0 || y_we0) begin
                chk(y_ce0 && y_we0, "y_ce_we", int'({y_ce0, y_we0}), 3);
                if (exp_y.size() == 0) chk(1'b0, "y_unexpected", int'(y_d0), -1);
                else begin
                    e_y = exp_y.pop_front();
                    chk(cyc == e_y.cyc, "y_cycle", cyc, e_y.cyc);
                    chk(int'(y_address0) == e_y.addr, "y_addr", int'(y_address0), e_y.addr);
                    chk(y_d0 == e_y.data, "y_data", int'(y_d0), int'(e_y.data));
                end
            end
            if (a_ce0 || x_ce0) begin
                chk(a_ce0 && x_ce0, "ce_pair", int'({a_ce0, x_ce0}), 3);
                chk(int'(a_address0) == rd_idx % 16, "a_addr", int'(a_address0), rd_idx % 16);
                chk(int'(x_address0) == rd_idx % 8, "x_addr", int'(x_address0), rd_idx % 8);
                rd_idx++;
            end
            if (prev_ce) begin
                chk(mul_din0 == amem[prev_a], "din0", int'(mul_din0), int'(amem[prev_a]));
                chk(mul_din1 == xmem[prev_x], "din1", int'(mul_din1), int'(xmem[prev_x]));
            end else begin
                chk(mul_din0 == 0 && mul_din1 == 0, "din_zero", int'(mul_din0), 0);
            end
            prev_ce = a_ce0;
            prev_a  = int'(a_address0);
            prev_x  = int'(x_address0);
        end
        if (fin_req && !fin_done) begin
            chk(exp_y.size() == 0, "y_missing", exp_y.size(), 0);
            chk(exp_done.size() == 0, "done_missing", exp_done.size(), 0);
            fin_done = 1'b1;
        end
    end

    task automatic go_to(input int t);
        while (cyc < t) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic run_one();
        int s;
        @(posedge ap_clk); #1;
        s = cyc;
        ap_start = 1'b1;
        push_run(s, ROWS, s + RUN);
        go_to(s + 1);
        ap_start = 1'b0;
        go_to(s + RUN + 5);
    endtask

    initial begin
        int s;
        for (int i = 0; i < 16; i++) amem[i] = (i < 8) ? 16'd1 : 16'(i - 7);
        for (int c = 0; c < 8; c++) xmem[c] = 16'(c + 1);
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        go_to(cyc + 2);

        run_one();  // 36 / 204

        for (int i = 0; i < 16; i++) amem[i] = (i < 8) ? 16'hFFFF : 16'd2;
        run_one();  // 0xFFDC / 72

        for (int i = 0; i < 16; i++) amem[i] = 16'd300;
        for (int c = 0; c < 8; c++) xmem[c] = 16'd300;
        run_one();  // wrap to 0xFC80

        // Reset during row 1: only row 0 is written, no done.
        for (int i = 0; i < 16; i++) amem[i] = 16'($urandom);
        for (int c = 0; c < 8; c++) xmem[c] = 16'($urandom);
        @(posedge ap_clk); #1;
        s = cyc;
        ap_start = 1'b1;
        push_run(s, 1, s + 20);
        go_to(s + 1);
        ap_start = 1'b0;
        go_to(s + 20);
        ap_rst = 1'b1;
        go_to(s + 21);
        ap_rst = 1'b0;
        go_to(s + 24);
        run_one();

        // Start pulses while busy must not disturb the run.
        @(posedge ap_clk); #1;
        s = cyc;
        ap_start = 1'b1;
        push_run(s, ROWS, s + RUN);
        go_to(s + 1);
        ap_start = 1'b0;
        go_to(s + 10); ap_start = 1'b1;
        go_to(s + 11); ap_start = 1'b0;
        go_to(s + 25); ap_start = 1'b1;
        go_to(s + 26); ap_start = 1'b0;
        go_to(s + RUN + 5);

        // Start held for 80 cycles: runs begin at s, s+36 and s+72.
        for (int i = 0; i < 16; i++) amem[i] = 16'($urandom_range(0, 255)) - 16'd128;
        @(posedge ap_clk); #1;
        s = cyc;
        ap_start = 1'b1;
        push_run(s, ROWS, s + RUN);
        push_run(s + RUN + 1, ROWS, s + 2 * RUN + 1);
        push_run(s + 2 * RUN + 2, ROWS, s + 3 * RUN + 2);
        go_to(s + 80);
        ap_start = 1'b0;
        go_to(s + 3 * RUN + 8);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) amem[i] = 16'($urandom);
            for (int c = 0; c < 8; c++) xmem[c] = 16'($urandom);
            run_one();
        end

        fin_req = 1'b1;
        repeat (3) @(posedge ap_clk);
        if (!fin_done) $display("FAIL final_check not reached");
        $display("CHECKS %0d ERRORS %0d", checks, fin_done ? errors : errors + 1);
        $finish;
    end
endmodule
